// File: rtl/mc_control.sv
// mc_control -- multi-cycle sequencer for the RiSC-16 core.
//
// The core has one shared memory port for instruction fetch and data access.
// This block steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It
// drives the datapath mux selects, the ALU function, the register/PC/IR load
// enables and the memory request handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   instr_op     IR opcode field instr[15:13]
//   alu_stat     ALU equality status (1 = operands equal)
//   mem_ready    memory accepts/completes the current request this cycle
//   mem_req      memory request
//   mem_we       memory write enable (meaningful only with mem_req)
//   mem_sel      memory address source: 0 = PC, 1 = ALU out
//   ir_load      load IR from memory read data
//   pc_load      load PC from the mux_pc selection
//   mux_pc       next-PC select (NPC / BRANCH / ALU)
//   mux_alua     ALU A operand select
//   mux_alub     ALU B operand select
//   mux_rt       register source-2 address select
//   mux_tgt      writeback data select
//   alu_funct    ALU operation
//   reg_writeEn  register file write enable
//   state        current state, for debug
//   bus_err      sticky memory-timeout flag
//
// state  | meaning
// -------+----------------------------------------------------------
// FETCH  | request instruction at PC, load IR on mem_ready
// DECODE | one idle cycle while register reads settle
// EXEC   | ALU operates; BEQ resolves and loads PC here
// MEM    | data access at ALU address; SW loads PC on completion
// WB     | register write and PC load on the same edge
// ERROR  | memory timeout (or illegal state code), held until reset

`ifndef FUNCT_LEN
`define FUNCT_LEN 2
`endif
`ifndef FUNCT_ADD
`define FUNCT_ADD   0
`define FUNCT_NAND  1
`define FUNCT_PASSA 2
`define FUNCT_SUB   3
`endif
`ifndef SEL_PC_NPC
`define SEL_PC_NPC    2'd0
`define SEL_PC_BRANCH 2'd1
`define SEL_PC_ALU    2'd2
`endif
`ifndef SEL_ALUA_REG
`define SEL_ALUA_REG 1'b0
`define SEL_ALUA_IMM 1'b1
`define SEL_ALUB_REG 1'b0
`define SEL_ALUB_IMM 1'b1
`endif
`ifndef SEL_RT_REGC
`define SEL_RT_REGC 1'b0
`define SEL_RT_REGA 1'b1
`endif
`ifndef SEL_TGT_ALU
`define SEL_TGT_ALU 2'd0
`define SEL_TGT_MEM 2'd1
`define SEL_TGT_NPC 2'd2
`endif

module mc_control #(
  parameter int unsigned WAIT_MAX  = 15,
  parameter int unsigned FUNCT_LEN = `FUNCT_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           instr_op,
  input  logic                 alu_stat,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_sel,
  output logic                 ir_load,
  output logic                 pc_load,
  output logic [1:0]           mux_pc,
  output logic                 mux_alua,
  output logic                 mux_alub,
  output logic                 mux_rt,
  output logic [1:0]           mux_tgt,
  output logic [FUNCT_LEN-1:0] alu_funct,
  output logic                 reg_writeEn,
  output logic [2:0]           state,
  output logic                 bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int          CW  = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int unsigned LIM = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;

  state_t        state_q;
  logic [CW-1:0] wait_cnt;
  logic          timeout;

  assign state = state_q;

  // The limit is hit on the cycle whose increment would reach WAIT_MAX.
  // mem_ready is checked first, so a handshake on that cycle still wins.
  assign timeout = (WAIT_MAX != 0) && (wait_cnt == CW'(LIM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state_q == S_FETCH)    state_q <= S_DECODE;
            else if (instr_op == OP_SW) state_q <= S_FETCH;
            else                        state_q <= S_WB;
          end else if (timeout) begin
            wait_cnt <= '0;
            state_q  <= S_ERROR;
            bus_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          case (instr_op)
            OP_SW, OP_LW: state_q <= S_MEM;
            OP_BEQ:       state_q <= S_FETCH;
            default:      state_q <= S_WB;
          endcase
        end
        S_WB:    state_q <= S_FETCH;
        S_ERROR: bus_err <= 1'b1;
        default: begin
          state_q <= S_ERROR;
          bus_err <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    reg_writeEn = 1'b0;
    mux_pc      = `SEL_PC_NPC;
    alu_funct   = FUNCT_LEN'(`FUNCT_ADD);
    mux_alua    = `SEL_ALUA_REG;
    mux_alub    = `SEL_ALUB_REG;
    mux_rt      = `SEL_RT_REGC;
    mux_tgt     = `SEL_TGT_ALU;

    if (state_q != S_ERROR) begin
      case (instr_op)
        OP_ADD: ;
        OP_ADDI: mux_alub = `SEL_ALUB_IMM;
        OP_NAND: alu_funct = FUNCT_LEN'(`FUNCT_NAND);
        OP_LUI: begin
          alu_funct = FUNCT_LEN'(`FUNCT_PASSA);
          mux_alua  = `SEL_ALUA_IMM;
        end
        OP_SW: begin
          mux_alub = `SEL_ALUB_IMM;
          mux_rt   = `SEL_RT_REGA;
        end
        OP_LW: begin
          mux_alub = `SEL_ALUB_IMM;
          mux_rt   = `SEL_RT_REGA;
          mux_tgt  = `SEL_TGT_MEM;
        end
        OP_BEQ: begin
          alu_funct = FUNCT_LEN'(`FUNCT_SUB);
          mux_rt    = `SEL_RT_REGA;
        end
        default: begin
          alu_funct = FUNCT_LEN'(`FUNCT_PASSA);
          mux_rt    = `SEL_RT_REGA;
          mux_tgt   = `SEL_TGT_NPC;
        end
      endcase
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      S_EXEC: begin
        if (instr_op == OP_BEQ) begin
          pc_load = 1'b1;
          if (alu_stat) mux_pc = `SEL_PC_BRANCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (instr_op == OP_SW);
        pc_load = mem_ready && (instr_op == OP_SW);
      end
      S_WB: begin
        reg_writeEn = 1'b1;
        pc_load     = 1'b1;
        if (instr_op == OP_JALR) mux_pc = `SEL_PC_ALU;
      end
      default: ;
    endcase

    // Reset kills every side effect immediately, not at the next edge.
    if (!reset) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_load     = 1'b0;
      pc_load     = 1'b0;
      reg_writeEn = 1'b0;
    end
  end

endmodule
